// File: rtl/selection_stage.sv
// Truncation selection: picks the NUM_SEL lowest-cost paths, best first, one candidate per clock.
// Optional macro SELECTION_FITOUT_EN adds the sel_fitness output carrying the cost of each selected slot.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | snapshot population/fitness, clear search bookkeeping
// SCAN  | compare candidate i against the running best
// STORE | commit best path to slot k, mark it used
// DONE  | done pulse, results on the output bus
module selection_stage #(
    parameter int NUM_PATHS = 50,
    parameter int NUM_SEL   = 10,
    parameter int PATH_W    = 150,
    parameter int FIT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_PATHS*PATH_W-1:0]   population,
    input  logic [NUM_PATHS*FIT_W-1:0]    fitness,
    output logic [NUM_SEL*PATH_W-1:0]     sel_population,
    output logic                          done
`ifdef SELECTION_FITOUT_EN
    ,
    output logic [NUM_SEL*FIT_W-1:0]      sel_fitness
`endif
);

    localparam int IW = $clog2(NUM_PATHS);
    localparam int KW = $clog2(NUM_SEL + 1);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_PATHS - 1);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_SEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_STORE,
        S_DONE
    } state_t;

    state_t                state;
    logic [PATH_W-1:0]     pop_q [NUM_PATHS];
    logic [FIT_W-1:0]      fit_q [NUM_PATHS];
    logic [PATH_W-1:0]     shadow_pop [NUM_SEL];
`ifdef SELECTION_FITOUT_EN
    logic [FIT_W-1:0]      shadow_fit [NUM_SEL];
`endif
    logic [NUM_PATHS-1:0]  used;
    logic [KW-1:0]         k;
    logic [IW-1:0]         i;
    logic                  best_valid;
    logic [FIT_W-1:0]      best_fit;
    logic [IW-1:0]         best_idx;
    logic                  win;

    // Strict less-than keeps the lowest index on ties; best_valid forces a pick even at all-ones cost.
    assign win = !used[i] && (!best_valid || (fit_q[i] < best_fit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            done           <= 1'b0;
            sel_population <= '0;
            used           <= '0;
            k              <= '0;
            i              <= '0;
            best_valid     <= 1'b0;
            best_fit       <= '0;
            best_idx       <= '0;
            for (int p = 0; p < NUM_PATHS; p++) begin
                pop_q[p] <= '0;
                fit_q[p] <= '0;
            end
            for (int s = 0; s < NUM_SEL; s++) begin
                shadow_pop[s] <= '0;
`ifdef SELECTION_FITOUT_EN
                shadow_fit[s] <= '0;
`endif
            end
`ifdef SELECTION_FITOUT_EN
            sel_fitness    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int p = 0; p < NUM_PATHS; p++) begin
                        pop_q[p] <= population[p*PATH_W +: PATH_W];
                        fit_q[p] <= fitness[p*FIT_W +: FIT_W];
                    end
                    used       <= '0;
                    k          <= '0;
                    i          <= '0;
                    best_valid <= 1'b0;
                    state      <= S_SCAN;
                end
                S_SCAN: begin
                    if (win) begin
                        best_fit   <= fit_q[i];
                        best_idx   <= i;
                        best_valid <= 1'b1;
                    end
                    if (i == LAST_I) begin
                        i     <= '0;
                        state <= S_STORE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_STORE: begin
                    shadow_pop[k]  <= pop_q[best_idx];
`ifdef SELECTION_FITOUT_EN
                    shadow_fit[k]  <= fit_q[best_idx];
`endif
                    used[best_idx] <= 1'b1;
                    best_valid     <= 1'b0;
                    i              <= '0;
                    k              <= k + 1'b1;
                    if (k == LAST_K) begin
                        // Output bus and done are loaded on the edge into DONE, so both are
                        // registered and valid together for the single DONE cycle.
                        state <= S_DONE;
                        done  <= 1'b1;
                        for (int s = 0; s < NUM_SEL; s++) begin
                            sel_population[s*PATH_W +: PATH_W] <=
                                (KW'(s) == k) ? pop_q[best_idx] : shadow_pop[s];
`ifdef SELECTION_FITOUT_EN
                            sel_fitness[s*FIT_W +: FIT_W] <=
                                (KW'(s) == k) ? fit_q[best_idx] : shadow_fit[s];
`endif
                        end
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
